mult_seq_ctrl: RTL
==================

// Module: mult_seq_ctrl
// PURPOSE
//  Sequencer for the 8x8 sequential multiplier built from one 4x4 multiplier,
//  nibble muxes, a shifter and an accumulator. On a start request it clears the
//  accumulator and steps through the four nibble products in four cycles.
//  It drives the mux selects, shift code and accumulator controls, then signals done.
//  Sits between the top-level handshake and the multiplier datapath.
// PARAMETERS
//  DONE_HOLD  0  0: done is a 1-cycle pulse; 1: done stays high until the next accepted start or abort
// PORTS
//  clk        in   1  system clock, rising edge
//  aclr       in   1  asynchronous reset, active-high
//  start      in   1  request new multiply; sampled only in IDLE or DONE
//  abort      in   1  synchronous abort; returns to IDLE, no done
//  sel_a      out  1  operand-A nibble select (0=a[3:0], 1=a[7:4])
//  sel_b      out  1  operand-B nibble select (0=b[3:0], 1=b[7:4])
//  shift      out  2  shift code: 0=<<0, 1=<<4, 2=<<8 (3 never driven)
//  acc_clr    out  1  synchronous clear for the accumulator
//  acc_en     out  1  accumulate enable for the current partial product
//  busy       out  1  high in CLEAR and CALC
//  done       out  1  result valid in accumulator
// BEHAVIOUR
//  - Reset (aclr=1, async): state=IDLE, step=0; all outputs 0.
//  - All outputs are registered (Moore). No combinational path from inputs to outputs.
//  - States: IDLE, CLEAR, CALC, DONE. Encoding is a localparam set, 2 bits.
//  - IDLE: start=1 -> CLEAR; otherwise stay.
//  - CLEAR (1 cycle): acc_clr=1, acc_en=0, step=0 -> CALC.
//  - CALC (4 cycles): acc_en=1. Step counter runs 0,1,2,3.
//      sel_a=step[1], sel_b=step[0], shift=step[1]+step[0].
//      step 3 -> DONE; the counter wraps to 0.
//  - DONE: done=1, busy=0.
//      start=1 -> CLEAR (back-to-back operation); no IDLE cycle is inserted.
//      Otherwise -> IDLE.
//      DONE_HOLD=1: done stays 1 in IDLE until the next accepted start or abort.
//  - Latency: with start sampled at edge k, acc_clr is high after edge k, and
//    acc_en is high after edges k+1..k+4. done rises after edge k+5.
//    Next start can be accepted at edge k+5 (throughput 5 cycles/op).
//  - start while busy is ignored (not queued).
//  - abort has priority over start in every state.
//    abort=1 -> IDLE, step=0; acc_en, acc_clr and done go to 0 next cycle.
//    The accumulator is not cleared by abort.
//  - start and abort high in the same cycle in IDLE: stay IDLE.
//  - Reset mid-CALC: immediate IDLE, outputs 0; no done is produced.
//  - sel_a, sel_b and shift are 0 whenever acc_en=0.
// STRUCTURE
//  - Shared package mult_pkg: state encoding localparams (ST_IDLE=0, ST_CLEAR=1,
//    ST_CALC=2, ST_DONE=3), SHIFT_0/4/8 codes, STEPS=4.
//  - Sub-module step_counter: 2-bit counter with en, sclr and terminal flag
//    (tc = step==3), async active-high reset. Instantiated once.
//  - FSM plus output registers live in mult_seq_ctrl.
// TESTING
//  1. aclr=1 for 2 cycles, then release -> all outputs 0, state IDLE; start idle 10 cycles -> outputs stay 0.
//  2. 1-cycle start pulse -> acc_clr 1 cycle; then acc_en 4 cycles with
//     (sel_a,sel_b,shift) = (0,0,0),(0,1,1),(1,0,1),(1,1,2); then done 1 cycle (DONE_HOLD=0).
//  3. start held high continuously -> repeating 5-cycle pattern CLEAR,CALCx4, with
//     done coinciding with the next acc_clr; start pulses in CALC have no effect.
//  4. abort at 2nd CALC cycle -> acc_en=0 next cycle, done never asserts, busy=0;
//     a new start then completes normally.
//  5. aclr asserted mid-CALC (between clock edges) -> outputs 0 immediately; after
//     release a full operation runs with correct step order.
//  6. DONE_HOLD=1 -> done stays high in IDLE for 20 cycles; drops after the edge
//     accepting the next start (acc_clr=1 that cycle) or after abort.
//  Bench: drive the real 8x8 datapath; check 255*255=65025, 0*173=0, 15*16=240, 128*3=384.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared encodings for the nibble-serial 8x8 multiplier: FSM states, shifter
// codes and the number of nibble products per operation.
package mult_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_CALC  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_CLEAR = ST_CLEAR,
    S_CALC  = ST_CALC,
    S_DONE  = ST_DONE
  } state_e;

  localparam logic [1:0] SHIFT_0 = 2'd0;
  localparam logic [1:0] SHIFT_4 = 2'd1;
  localparam logic [1:0] SHIFT_8 = 2'd2;

  localparam int STEPS  = 4;
  localparam int STEP_W = $clog2(STEPS);

  // Shift amount is the count of high nibbles selected: (lo,lo)=0, mixed=4, (hi,hi)=8.
  function automatic logic [1:0] shift_code(input logic [1:0] step);
    case (step)
      2'b00:   return SHIFT_0;
      2'b11:   return SHIFT_8;
      default: return SHIFT_4;
    endcase
  endfunction

endpackage

// File: rtl/step_counter.sv
// Nibble-product step counter: wraps at STEPS-1, flags the last step, and
// exposes its next value so the sequencer can register its decoded selects.
module step_counter
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              aclr,
  input  logic              en,
  input  logic              sclr,
  output logic [STEP_W-1:0] step_next,
  output logic              tc
);

  localparam logic [STEP_W-1:0] ONE  = STEP_W'(1);
  localparam logic [STEP_W-1:0] LAST = STEP_W'(STEPS - 1);

  logic [STEP_W-1:0] count_q;
  logic [STEP_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (sclr)
      count_d = '0;
    else if (en)
      count_d = count_q + ONE;
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign step_next = count_d;
  assign tc        = (count_q == LAST);

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencer for the 8x8 multiplier built from one 4x4 multiplier: clears the
// accumulator, walks the four nibble products, then flags done. Moore outputs.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int DONE_HOLD = 0
) (
  input  logic       clk,
  input  logic       aclr,
  input  logic       start,
  input  logic       abort,
  output logic       sel_a,
  output logic       sel_b,
  output logic [1:0] shift,
  output logic       acc_clr,
  output logic       acc_en,
  output logic       busy,
  output logic       done
);

  localparam logic HOLD = (DONE_HOLD != 0);

  state_e            state_q, state_d;
  logic              sel_a_q, sel_a_d;
  logic              sel_b_q, sel_b_d;
  logic [1:0]        shift_q, shift_d;
  logic              acc_clr_q, acc_clr_d;
  logic              acc_en_q, acc_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              cnt_en;
  logic              last_step;
  logic [STEP_W-1:0] step_next;

  assign cnt_en = (state_q == S_CALC) && !abort;

  step_counter u_step (
    .clk       (clk),
    .aclr      (aclr),
    .en        (cnt_en),
    .sclr      (!cnt_en),
    .step_next (step_next),
    .tc        (last_step)
  );

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!abort && start)
          state_d = S_CLEAR;
        else if (!abort)
          done_d = HOLD & done_q;
      end
      S_CLEAR: state_d = abort ? S_IDLE : S_CALC;
      S_CALC: begin
        if (abort)
          state_d = S_IDLE;
        else if (last_step) begin
          // The edge ending the last product is also the start-acceptance
          // point, so a held start restarts with done and acc_clr together.
          state_d = start ? S_CLEAR : S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        if (abort)
          state_d = S_IDLE;
        else if (start)
          state_d = S_CLEAR;
        else begin
          state_d = S_IDLE;
          done_d  = HOLD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    acc_clr_d = (state_d == S_CLEAR);
    acc_en_d  = (state_d == S_CALC);
    busy_d    = acc_clr_d | acc_en_d;
    sel_a_d   = acc_en_d & step_next[1];
    sel_b_d   = acc_en_d & step_next[0];
    shift_d   = acc_en_d ? shift_code(step_next) : SHIFT_0;
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q   <= S_IDLE;
      sel_a_q   <= 1'b0;
      sel_b_q   <= 1'b0;
      shift_q   <= SHIFT_0;
      acc_clr_q <= 1'b0;
      acc_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_a_q   <= sel_a_d;
      sel_b_q   <= sel_b_d;
      shift_q   <= shift_d;
      acc_clr_q <= acc_clr_d;
      acc_en_q  <= acc_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign sel_a   = sel_a_q;
  assign sel_b   = sel_b_q;
  assign shift   = shift_q;
  assign acc_clr = acc_clr_q;
  assign acc_en  = acc_en_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
